// File: rtl/proc_trace_checker_pkg.sv
// rtl/proc_trace_checker_pkg.sv - shared types and defaults for the trace checker
package proc_trace_checker_pkg;

  localparam int DEFAULT_DEPTH   = 64;
  localparam int DEFAULT_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        dc;
  } trace_entry_t;

endpackage

// File: rtl/proc_trace_checker_table.sv
// rtl/proc_trace_checker_table.sv - expected-trace storage, sync write, async read, no reset
module proc_trace_checker_table
  import proc_trace_checker_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int IDXW  = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [IDXW-1:0] waddr,
  input  trace_entry_t    wdata,
  input  logic [IDXW-1:0] raddr,
  output trace_entry_t    rdata
);

  trace_entry_t mem [DEPTH];

  // Table contents survive reset so a new run can reuse a preloaded table.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/proc_trace_checker.sv
// rtl/proc_trace_checker.sv - in-order trace checker; PROC_TRACE_CHECKER_CYCLES_EN adds a RUN cycle counter
module proc_trace_checker
  import proc_trace_checker_pkg::*;
#(
  parameter int DEPTH   = DEFAULT_DEPTH,
  parameter int IDXW    = $clog2(DEPTH),
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ld_en,
  input  logic [IDXW-1:0] ld_idx,
  input  logic [31:0]     ld_addr,
  input  logic [31:0]     ld_data,
  input  logic            ld_dc,
  input  logic            start,
  input  logic [IDXW:0]   num,
  input  logic            trace_val,
  input  logic [31:0]     trace_addr,
  input  logic [31:0]     trace_data,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timeout,
  output logic [IDXW:0]   fail_idx,
  output logic [31:0]     got_addr,
  output logic [31:0]     got_data
`ifdef PROC_TRACE_CHECKER_CYCLES_EN
  ,
  output logic [31:0]     cycles
`endif
);

  localparam int            CNTW       = $clog2(TIMEOUT) + 1;
  localparam logic [CNTW-1:0] IDLE_LIMIT = CNTW'(TIMEOUT - 1);
  localparam logic [CNTW-1:0] CNT_ONE    = CNTW'(1);
  localparam logic [IDXW:0] DEPTH_N    = (IDXW + 1)'(DEPTH);
  localparam logic [IDXW:0] IDX_ONE    = (IDXW + 1)'(1);

  state_t          state, state_nx;
  logic [IDXW:0]   idx, num_q, num_clamp, idx_inc;
  logic [CNTW-1:0] idle_cnt;
  trace_entry_t    exp_entry;
  logic            hit, start_ok, idle_expired;

  proc_trace_checker_table #(
    .DEPTH (DEPTH),
    .IDXW  (IDXW)
  ) u_table (
    .clk   (clk),
    .we    (ld_en && (state != RUN)),
    .waddr (ld_idx),
    .wdata ('{addr: ld_addr, data: ld_data, dc: ld_dc}),
    .raddr (idx[IDXW-1:0]),
    .rdata (exp_entry)
  );

  // Compare the live trace record against the expected entry and pick the next state.
  always_comb begin
    state_nx     = state;
    hit          = (trace_addr == exp_entry.addr) &&
                   (exp_entry.dc || (trace_data == exp_entry.data));
    start_ok     = start && (state != RUN);
    num_clamp    = (num > DEPTH_N) ? DEPTH_N : num;
    idx_inc      = idx + IDX_ONE;
    idle_expired = (idle_cnt >= IDLE_LIMIT);
    unique case (state)
      RUN: begin
        if (trace_val) begin
          if (!hit)                  state_nx = FAIL;
          else if (idx_inc == num_q) state_nx = PASS;
        end else if (idle_expired) begin
          state_nx = FAIL;
        end
      end
      default: begin
        if (start) state_nx = (num_clamp != '0) ? RUN : PASS;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Run bookkeeping: entry index, idle counter and failure diagnostics.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx      <= '0;
      num_q    <= '0;
      idle_cnt <= '0;
      timeout  <= 1'b0;
      fail_idx <= '0;
      got_addr <= '0;
      got_data <= '0;
    end else if (start_ok) begin
      idx      <= '0;
      num_q    <= num_clamp;
      idle_cnt <= '0;
      timeout  <= 1'b0;
      fail_idx <= '0;
      got_addr <= '0;
      got_data <= '0;
    end else if (state == RUN) begin
      if (trace_val) begin
        idle_cnt <= '0;
        if (hit) begin
          idx <= idx_inc;
        end else begin
          fail_idx <= idx;
          got_addr <= trace_addr;
          got_data <= trace_data;
        end
      end else if (idle_expired) begin
        timeout  <= 1'b1;
        fail_idx <= idx;
        got_addr <= '0;
        got_data <= '0;
      end else if (idle_cnt != '1) begin
        idle_cnt <= idle_cnt + CNT_ONE;
      end
    end
  end

`ifdef PROC_TRACE_CHECKER_CYCLES_EN
  // Count cycles spent in RUN; frozen once a verdict is reached.
  always_ff @(posedge clk) begin
    if (rst)               cycles <= '0;
    else if (start_ok)     cycles <= '0;
    else if (state == RUN) cycles <= cycles + 32'd1;
  end
`endif

  assign busy = (state == RUN);
  assign done = (state == PASS) || (state == FAIL);
  assign pass = (state == PASS);

endmodule

// File: tb/tb_proc_trace_checker.sv
// tb/tb_proc_trace_checker.sv - self-checking bench for proc_trace_checker
module tb_proc_trace_checker;

  localparam int DEPTH   = 8;
  localparam int IDXW    = 3;
  localparam int TIMEOUT = 8;
  localparam int NSTIM   = 88;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            ld_en = 1'b0;
  logic [IDXW-1:0] ld_idx = '0;
  logic [31:0]     ld_addr = '0;
  logic [31:0]     ld_data = '0;
  logic            ld_dc = 1'b0;
  logic            start = 1'b0;
  logic [IDXW:0]   num = '0;
  logic            trace_val = 1'b0;
  logic [31:0]     trace_addr = '0;
  logic [31:0]     trace_data = '0;
  logic            busy, done, pass, timeout;
  logic [IDXW:0]   fail_idx;
  logic [31:0]     got_addr, got_data;
`ifdef PROC_TRACE_CHECKER_CYCLES_EN
  logic [31:0]     cycles;
`endif

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] mt_addr [DEPTH];
  logic [31:0] mt_data [DEPTH];
  logic        mt_dc   [DEPTH];

  logic        sv [NSTIM];
  logic [31:0] sa [NSTIM];
  logic [31:0] sd [NSTIM];

  typedef struct {
    logic [31:0] ea;
    logic [31:0] ed;
    logic        dc;
    logic [31:0] ta;
    logic [31:0] td;
    logic        ep;
  } vec_t;
  vec_t vecs [6];

  always #5 clk = ~clk;

  proc_trace_checker #(.DEPTH(DEPTH), .IDXW(IDXW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .ld_en(ld_en), .ld_idx(ld_idx), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_dc(ld_dc), .start(start), .num(num),
    .trace_val(trace_val), .trace_addr(trace_addr), .trace_data(trace_data),
    .busy(busy), .done(done), .pass(pass), .timeout(timeout),
    .fail_idx(fail_idx), .got_addr(got_addr), .got_data(got_data)
`ifdef PROC_TRACE_CHECKER_CYCLES_EN
    , .cycles(cycles)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic load(input int i, input logic [31:0] a, input logic [31:0] d, input logic dc);
    ld_en = 1'b1; ld_idx = i[IDXW-1:0]; ld_addr = a; ld_data = d; ld_dc = dc;
    @(posedge clk); #1;
    ld_en = 1'b0;
    mt_addr[i] = a; mt_data[i] = d; mt_dc[i] = dc;
  endtask

  task automatic do_start(input int n);
    start = 1'b1; num = n[IDXW:0];
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic [31:0] d);
    trace_val = v; trace_addr = a; trace_data = d;
    @(posedge clk); #1;
    trace_val = 1'b0;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Reference: walk the record list; a run ends on the n-th match, the first
  // mismatch, or the TIMEOUT-th consecutive quiet cycle.
  task automatic predict(input int n, output int vc, output logic ps, output logic tmo,
                         output int fi, output logic [31:0] ga, output logic [31:0] gd);
    int matched, gap;
    matched = 0; gap = 0; vc = -1; ps = 0; tmo = 0; fi = 0; ga = 0; gd = 0;
    for (int c = 0; c < NSTIM; c++) begin
      if (sv[c]) begin
        gap = 0;
        if (sa[c] == mt_addr[matched] && (mt_dc[matched] || sd[c] == mt_data[matched])) begin
          matched++;
          if (matched == n) begin vc = c; ps = 1; fi = 0; return; end
        end else begin
          vc = c; fi = matched; ga = sa[c]; gd = sd[c]; return;
        end
      end else begin
        gap++;
        if (gap == TIMEOUT) begin vc = c; tmo = 1; fi = matched; return; end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vc, fi, g, r, n, ne;
    logic ps, tmo;
    logic [31:0] ga, gd;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_fail_idx", fail_idx, 0);
    chk("rst_got_addr", got_addr, 0);
    chk("rst_got_data", got_data, 0);
`ifdef PROC_TRACE_CHECKER_CYCLES_EN
    chk("rst_cycles", cycles, 0);
`endif

    // Single-record vectors.
    vecs[0] = '{32'h208, 32'h0, 1'b1, 32'h208, 32'hdeadbeef, 1'b1};
    vecs[1] = '{32'h200, 32'h2, 1'b0, 32'h200, 32'h2, 1'b1};
    vecs[2] = '{32'h200, 32'h2, 1'b0, 32'h200, 32'h3, 1'b0};
    vecs[3] = '{32'h200, 32'h2, 1'b1, 32'h204, 32'h2, 1'b0};
    vecs[4] = '{32'hfffffffc, 32'hffffffff, 1'b0, 32'hfffffffc, 32'hffffffff, 1'b1};
    vecs[5] = '{32'h0, 32'h0, 1'b0, 32'h1, 32'h0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      load(0, vecs[i].ea, vecs[i].ed, vecs[i].dc);
      do_start(1);
      step(1'b1, vecs[i].ta, vecs[i].td);
      chk($sformatf("vec%0d_done", i), done, 1);
      chk($sformatf("vec%0d_pass", i), pass, vecs[i].ep);
      chk($sformatf("vec%0d_busy", i), busy, 0);
      chk($sformatf("vec%0d_fail_idx", i), fail_idx, 0);
      chk($sformatf("vec%0d_got_addr", i), got_addr, vecs[i].ep ? 32'h0 : vecs[i].ta);
      chk($sformatf("vec%0d_got_data", i), got_data, vecs[i].ep ? 32'h0 : vecs[i].td);
    end

    // Basic two-record pass.
    load(0, 32'h200, 32'h2, 1'b0);
    load(1, 32'h204, 32'h3, 1'b0);
    do_start(2);
    chk("bp_busy_start", busy, 1);
    step(1'b1, 32'h200, 32'h2);
    chk("bp_busy_mid", busy, 1);
    chk("bp_done_mid", done, 0);
    step(1'b1, 32'h204, 32'h3);
    chk("bp_pass", pass, 1);
    chk("bp_done", done, 1);
    chk("bp_busy_end", busy, 0);

    // Data mismatch on entry 1, then verdict stays sticky.
    do_start(2);
    step(1'b1, 32'h200, 32'h2);
    step(1'b1, 32'h204, 32'h7);
    chk("dm_done", done, 1);
    chk("dm_pass", pass, 0);
    chk("dm_fail_idx", fail_idx, 1);
    chk("dm_got_addr", got_addr, 32'h204);
    chk("dm_got_data", got_data, 32'h7);
    chk("dm_timeout", timeout, 0);
    repeat (3) step(1'b1, $urandom, $urandom);
    chk("dm_sticky_idx", fail_idx, 1);
    chk("dm_sticky_data", got_data, 32'h7);
    chk("dm_sticky_done", done, 1);
    chk("dm_sticky_pass", pass, 0);

    // Reset from FAIL clears diagnostics.
    pulse_rst();
    chk("rf_done", done, 0);
    chk("rf_fail_idx", fail_idx, 0);
    chk("rf_got_data", got_data, 0);

    // Timeout: verdict exactly TIMEOUT cycles after entering RUN.
    load(0, 32'h300, 32'h30, 1'b0);
    do_start(1);
    for (int k = 0; k < TIMEOUT - 1; k++) begin
      step(1'b0, 32'h0, 32'h0);
      chk("to_busy", busy, 1);
    end
    step(1'b0, 32'h0, 32'h0);
    chk("to_done", done, 1);
    chk("to_pass", pass, 0);
    chk("to_timeout", timeout, 1);
    chk("to_fail_idx", fail_idx, 0);
    chk("to_got_addr", got_addr, 0);

    // A record on the last allowed cycle rescues the run.
    do_start(1);
    repeat (TIMEOUT - 1) step(1'b0, 32'h0, 32'h0);
    chk("tr_busy", busy, 1);
    step(1'b1, 32'h300, 32'h30);
    chk("tr_pass", pass, 1);
    chk("tr_timeout", timeout, 0);

    // num = 0 passes immediately.
    do_start(0);
    chk("n0_pass", pass, 1);
    chk("n0_busy", busy, 0);

    // Reset mid-RUN, then reuse the retained table.
    do_start(2);
    step(1'b1, 32'h300, 32'h30);
    pulse_rst();
    chk("rr_busy", busy, 0);
    chk("rr_done", done, 0);
    chk("rr_pass", pass, 0);
    do_start(2);
    step(1'b1, 32'h300, 32'h30);
    step(1'b1, 32'h204, 32'h3);
    chk("rr_repass", pass, 1);

    // Loads during RUN are ignored.
    do_start(2);
    ld_en = 1'b1; ld_idx = 3'd1; ld_addr = 32'hbad; ld_data = 32'hbad; ld_dc = 1'b1;
    step(1'b1, 32'h300, 32'h30);
    ld_en = 1'b0;
    step(1'b1, 32'h204, 32'h3);
    chk("lr_pass1", pass, 1);
    do_start(2);
    step(1'b1, 32'h300, 32'h30);
    step(1'b1, 32'h204, 32'h3);
    chk("lr_pass2", pass, 1);

    // num above DEPTH is clamped.
    for (int i = 0; i < DEPTH; i++) load(i, 32'h1000 + 4 * i, 32'h50 + i, 1'b0);
    do_start(15);
    for (int i = 0; i < DEPTH - 1; i++) step(1'b1, 32'h1000 + 4 * i, 32'h50 + i);
    chk("cl_busy", busy, 1);
    step(1'b1, 32'h1000 + 4 * (DEPTH - 1), 32'h50 + DEPTH - 1);
    chk("cl_pass", pass, 1);

`ifdef PROC_TRACE_CHECKER_CYCLES_EN
    do_start(3);
    step(1'b1, 32'h1000, 32'h50);
    step(1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h1004, 32'h51);
    step(1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h1008, 32'h52);
    chk("cy_pass", pass, 1);
    chk("cy_count", cycles, 5);
    step(1'b0, 32'h0, 32'h0);
    step(1'b1, 32'h0, 32'h0);
    chk("cy_frozen", cycles, 5);
`endif

    // Randomised runs against the reference.
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < DEPTH; i++)
        load(i, $urandom & 32'hfffffffc, $urandom, ($urandom_range(0, 3) == 0));
      n = $urandom_range(0, 15);
      ne = (n > DEPTH) ? DEPTH : n;
      do_start(n);
      if (ne == 0) begin
        chk("rnd_n0_pass", pass, 1);
        continue;
      end
      g = 0;
      for (int c = 0; c < NSTIM; c++) begin
        r = $urandom_range(0, 19);
        sv[c] = 1'b1;
        sa[c] = mt_addr[g % DEPTH];
        sd[c] = mt_dc[g % DEPTH] ? $urandom : mt_data[g % DEPTH];
        if (r == 0) begin
          for (int k = 0; k < TIMEOUT + 1 && c < NSTIM; k++) begin
            sv[c] = 1'b0; sa[c] = $urandom; sd[c] = $urandom; c++;
          end
          c--;
        end else if (r < 5) begin
          sv[c] = 1'b0;
        end else if (r == 5) begin
          if (mt_dc[g % DEPTH]) sa[c] = sa[c] ^ 32'h4;
          else                  sd[c] = sd[c] ^ 32'h1;
        end else begin
          g++;
        end
      end
      predict(ne, vc, ps, tmo, fi, ga, gd);
      for (int c = 0; c < ((vc < 0) ? NSTIM : vc + 3) && c < NSTIM; c++) begin
        step(sv[c], sa[c], sd[c]);
        chk("rnd_busy", busy, (vc < 0) || (c < vc));
        chk("rnd_done", done, (vc >= 0) && (c >= vc));
      end
      if (vc >= 0) begin
        chk("rnd_pass", pass, ps);
        chk("rnd_timeout", timeout, tmo);
        chk("rnd_fail_idx", fail_idx, ps ? 0 : fi);
        chk("rnd_got_addr", got_addr, ga);
        chk("rnd_got_data", got_data, gd);
      end else begin
        pulse_rst();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/proc_trace_checker.md
Name: proc_trace_checker

Overview:
Synthesizable consumer of the processor's trace port (trace_val/trace_addr/trace_data). It checks each retired-instruction trace record, in order, against an expected-trace table that is preloaded over a write port. It reports pass, fail, or timeout with diagnostic capture. It sits beside the processor in FPGA bring-up builds, standing in for the simulation-only trace check task.

Parameters:
DEPTH, 64, number of expected-trace entries (power of two, at least 2)
IDXW, $clog2(DEPTH), index width
TIMEOUT, 1024, maximum consecutive RUN cycles without trace_val before a timeout failure

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ld_en  in  1  write one expected entry (accepted only in IDLE)
ld_idx  in  IDXW  entry index to write
ld_addr  in  32  expected trace_addr
ld_data  in  32  expected trace_data
ld_dc  in  1  data don't-care: skip the data compare for this entry
start  in  1  begin checking (accepted only in IDLE)
num  in  IDXW+1  number of entries to check, latched on start, range 0..DEPTH
trace_val  in  1  processor trace record valid
trace_addr  in  32  processor trace address
trace_data  in  32  processor trace data
busy  out  1  high in RUN
done  out  1  high in PASS or FAIL
pass  out  1  high in PASS
timeout  out  1  failure was caused by timeout
fail_idx  out  IDXW+1  entry index at the failure
got_addr  out  32  trace_addr captured at the mismatch
got_data  out  32  trace_data captured at the mismatch

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE. All outputs 0. Internal index and idle counter 0. Table contents are not reset.
- States: IDLE, RUN, PASS, FAIL, encoded as a 2-bit enum.
- IDLE:
  - ld_en writes {ld_addr, ld_data, ld_dc} to table[ld_idx] at the clock edge.
  - start latches num and clears idx, the idle counter, fail_idx, got_*, and timeout.
  - Next state is RUN if num > 0, otherwise PASS.
  - If ld_en and start are both high in the same cycle, the write happens first; checking begins the next cycle.
  - num > DEPTH is clamped to DEPTH.
- RUN:
  - ld_en and start are ignored.
  - Each cycle with trace_val high, compare against table[idx]:
    - addr must be equal;
    - data must be equal unless the entry's ld_dc is set.
  - Match: idx increments and the idle counter clears. If idx == num-1, go to PASS.
  - Mismatch: go to FAIL and capture fail_idx = idx, got_addr = trace_addr, got_data = trace_data. timeout stays 0.
  - Cycle with trace_val low: the idle counter increments. When the counter reaches TIMEOUT-1 with trace_val still low, go to FAIL with timeout = 1, fail_idx = idx, and got_* = 0.
  - The compare path is combinational. The verdict is visible one cycle after the deciding trace_val cycle.
- PASS and FAIL: sticky. trace_val is ignored. Only rst or start leaves these states; start re-enters via the same rules as in IDLE, with the table retained. ld_en is also accepted in these states.
- Output decode: busy = (RUN); done = (PASS | FAIL); pass = (PASS). These are registered state decodes.
- Reset mid-RUN: returns to IDLE at once. The table survives, so a new start reuses it.
- Widths: idx and fail_idx are IDXW+1 bits. The idle counter is $clog2(TIMEOUT)+1 bits and saturates.

Optional Feature:
PROC_TRACE_CHECKER_CYCLES_EN
- Defined: adds output cycles, 32 bits. It clears on start, increments every RUN cycle, and freezes in PASS/FAIL. It is 0 after reset.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Decomposition:
- Package proc_trace_checker_pkg holds:
  - the state enum (IDLE, RUN, PASS, FAIL);
  - the packed struct trace_entry_t {addr[31:0], data[31:0], dc};
  - the default DEPTH and TIMEOUT localparams.
- One sub-module, proc_trace_checker_table: DEPTH x trace_entry_t storage with synchronous write and combinational read, no reset.
- The FSM, counters, and compare logic live in the top module.

Test Plan:
- Basic pass: load {0x200,0x2 dc=0}, {0x204,0x3 dc=0}; start num=2; drive the same two records -> pass=1 and done=1 the cycle after the second record; busy falls at the same time.
- Don't-care data: entry {0x208, dc=1}; drive addr 0x208, data 0xdeadbeef -> pass=1.
- Data mismatch: entry 1 expects {0x204,0x3}; drive {0x204,0x7} -> FAIL, fail_idx=1, got_data=0x7, timeout=0; later trace_val activity leaves the outputs unchanged.
- Timeout: TIMEOUT=8, num=1, no trace_val -> FAIL with timeout=1 and fail_idx=0 exactly 8 cycles after entering RUN. Also drive trace_val on cycle 7 with a matching record -> pass instead.
- Edges: start with num=0 -> PASS next cycle. rst asserted mid-RUN -> IDLE with all outputs 0; a fresh start then passes against the retained table. ld_en during RUN -> the table is unchanged, as verified by a subsequent run.
- Cycles feature (macro defined): a 3-record run with 2 gap cycles -> cycles=5 once PASS is reached.
